// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - shared constants for the UART receive FIFO
package uart_fifo_pkg;

    localparam int DATA_LSB = 0;
    localparam int DATA_MSB = 7;
    localparam int PE_BIT   = 8;
    localparam int FE_BIT   = 9;

    // FCR[7:6] receiver trigger field
    typedef enum logic [1:0] {
        FCR_TRIG_1  = 2'b00,
        FCR_TRIG_4  = 2'b01,
        FCR_TRIG_8  = 2'b10,
        FCR_TRIG_14 = 2'b11
    } fcr_trig_e;

    localparam logic [4:0] THR_TRIG_1  = 5'd1;
    localparam logic [4:0] THR_TRIG_4  = 5'd4;
    localparam logic [4:0] THR_TRIG_8  = 5'd8;
    localparam logic [4:0] THR_TRIG_14 = 5'd14;

    function automatic logic [4:0] fcr_to_thr(input fcr_trig_e trig);
        logic [4:0] thr;
        thr = THR_TRIG_1;
        case (trig)
            FCR_TRIG_1:  thr = THR_TRIG_1;
            FCR_TRIG_4:  thr = THR_TRIG_4;
            FCR_TRIG_8:  thr = THR_TRIG_8;
            FCR_TRIG_14: thr = THR_TRIG_14;
            default:     thr = THR_TRIG_1;
        endcase
        return thr;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// rtl/fifo_dpram.sv - one synchronous write port, one asynchronous read port
module fifo_dpram #(
    parameter int DATA_WIDTH    = 10,
    parameter int POINTER_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [POINTER_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [POINTER_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    localparam int DEPTH = 1 << POINTER_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fifo_lvl.sv
// rtl/rx_fifo_lvl.sv - UART receive FIFO with fill level, trigger threshold and sticky errors
module rx_fifo_lvl
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 10,
    parameter int POINTER_WIDTH = 4,
    parameter int FWFT          = 1,
    parameter int RESET_THR     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     rd,
    output logic [DATA_WIDTH-1:0]    data_out,
    input  logic                     flush,
    input  logic [POINTER_WIDTH:0]   thr_level,
    input  logic                     clr_err,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [POINTER_WIDTH:0]   fifo_level,
    output logic                     fifo_thr,
    output logic                     fifo_ov,
    output logic                     fifo_ud
);

    localparam int PW = POINTER_WIDTH;
    localparam logic [PW:0] DEPTH_L     = {1'b1, {PW{1'b0}}};
    localparam logic [PW:0] RESET_THR_L = RESET_THR[PW:0];

    logic [PW:0]           w_ptr;
    logic [PW:0]           r_ptr;
    logic                  re;
    logic                  we;
    logic                  ov_set;
    logic                  ud_set;
    logic [PW:0]           next_level;
    logic [PW:0]           eff_thr;
    logic [DATA_WIDTH-1:0] rd_data;

    assign fifo_empty = (w_ptr == r_ptr);
    assign fifo_full  = (w_ptr[PW] != r_ptr[PW]) && (w_ptr[PW-1:0] == r_ptr[PW-1:0]);

    // A full FIFO still takes a write when the head is popped in the same cycle.
    assign re     = rd & ~fifo_empty;
    assign we     = wr & (~fifo_full | re);
    assign ov_set = wr & fifo_full & ~re;
    assign ud_set = rd & fifo_empty;

    always_comb begin
        next_level = fifo_level;
        case ({we, re})
            2'b10:   next_level = fifo_level + 1'b1;
            2'b01:   next_level = fifo_level - 1'b1;
            default: next_level = fifo_level;
        endcase
    end

    always_comb begin
        eff_thr = thr_level;
        if (thr_level == '0) begin
            eff_thr = RESET_THR_L;
        end else if (thr_level > DEPTH_L) begin
            eff_thr = DEPTH_L;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            w_ptr      <= '0;
            r_ptr      <= '0;
            fifo_level <= '0;
            fifo_thr   <= 1'b0;
            fifo_ov    <= 1'b0;
            fifo_ud    <= 1'b0;
        end else begin
            if (we) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (re) begin
                r_ptr <= r_ptr + 1'b1;
            end
            fifo_level <= next_level;
            fifo_thr   <= (next_level >= eff_thr);
            // A new error event wins over a clear arriving in the same cycle.
            fifo_ov    <= ov_set | (fifo_ov & ~clr_err);
            fifo_ud    <= ud_set | (fifo_ud & ~clr_err);
        end
    end

    fifo_dpram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .POINTER_WIDTH (PW)
    ) u_mem (
        .clk   (clk),
        .we    (we & rst_n & ~flush),
        .waddr (w_ptr[PW-1:0]),
        .wdata (data_in),
        .raddr (r_ptr[PW-1:0]),
        .rdata (rd_data)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = rd_data;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else if (re && !flush) begin
                    dout_q <= rd_data;
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_rx_fifo_lvl.sv
// tb/tb_rx_fifo_lvl.sv - randomized and directed check of rx_fifo_lvl against a queue model
module tb_rx_fifo_lvl;

    localparam int DW    = 10;
    localparam int PW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr;
    logic [DW-1:0] data_in;
    logic          rd;
    logic          flush;
    logic [PW:0]   thr_level;
    logic          clr_err;

    logic [DW-1:0] a_data_out, b_data_out;
    logic          a_empty, a_full, a_thr, a_ov, a_ud;
    logic          b_empty, b_full, b_thr, b_ov, b_ud;
    logic [PW:0]   a_level, b_level;

    always #5 clk = ~clk;

    rx_fifo_lvl #(.DATA_WIDTH(DW), .POINTER_WIDTH(PW), .FWFT(1), .RESET_THR(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .rd(rd),
        .data_out(a_data_out), .flush(flush), .thr_level(thr_level), .clr_err(clr_err),
        .fifo_empty(a_empty), .fifo_full(a_full), .fifo_level(a_level),
        .fifo_thr(a_thr), .fifo_ov(a_ov), .fifo_ud(a_ud)
    );

    rx_fifo_lvl #(.DATA_WIDTH(DW), .POINTER_WIDTH(PW), .FWFT(0), .RESET_THR(1)) u_reg (
        .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .rd(rd),
        .data_out(b_data_out), .flush(flush), .thr_level(thr_level), .clr_err(clr_err),
        .fifo_empty(b_empty), .fifo_full(b_full), .fifo_level(b_level),
        .fifo_thr(b_thr), .fifo_ov(b_ov), .fifo_ud(b_ud)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_q[$];
    bit            m_ov, m_ud, m_thr;
    logic [DW-1:0] m_dout_reg;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int eff_thr(input int t);
        if (t == 0) return 1;
        return (t > DEPTH) ? DEPTH : t;
    endfunction

    task automatic model_step();
        bit empty, full, acc_rd, acc_wr, ov_ev, ud_ev;
        if (!rst_n || flush) begin
            m_q.delete();
            m_ov  = 0;
            m_ud  = 0;
            m_thr = 0;
            if (!rst_n) m_dout_reg = '0;
        end else begin
            empty  = (m_q.size() == 0);
            full   = (m_q.size() == DEPTH);
            acc_rd = rd && !empty;
            acc_wr = wr && (!full || acc_rd);
            ov_ev  = wr && full && !acc_rd;
            ud_ev  = rd && empty;
            if (acc_rd) m_dout_reg = m_q.pop_front();
            if (acc_wr) m_q.push_back(data_in);
            m_ov  = ov_ev || (m_ov && !clr_err);
            m_ud  = ud_ev || (m_ud && !clr_err);
            m_thr = (m_q.size() >= eff_thr(int'(thr_level)));
        end
    endtask

    task automatic check_all();
        int lvl;
        lvl = m_q.size();
        check_eq("level_a", a_level, lvl);
        check_eq("level_b", b_level, lvl);
        check_eq("empty_a", a_empty, lvl == 0);
        check_eq("empty_b", b_empty, lvl == 0);
        check_eq("full_a",  a_full,  lvl == DEPTH);
        check_eq("full_b",  b_full,  lvl == DEPTH);
        check_eq("thr_a",   a_thr,   m_thr);
        check_eq("thr_b",   b_thr,   m_thr);
        check_eq("ov_a",    a_ov,    m_ov);
        check_eq("ov_b",    b_ov,    m_ov);
        check_eq("ud_a",    a_ud,    m_ud);
        check_eq("ud_b",    b_ud,    m_ud);
        check_eq("dout_reg", b_data_out, m_dout_reg);
        if (lvl > 0) check_eq("dout_fwft", a_data_out, m_q[0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic w, input logic [DW-1:0] d, input logic r,
                         input logic f, input logic c);
        wr = w; data_in = d; rd = r; flush = f; clr_err = c;
        tick();
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; wr = 0; rd = 0; flush = 0; clr_err = 0; data_in = '0; thr_level = '0;
        m_dout_reg = '0;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        idle();

        // basic FWFT ordering
        drive(1, 10'h101, 0, 0, 0);
        drive(1, 10'h102, 0, 0, 0);
        drive(1, 10'h103, 0, 0, 0);
        idle();
        check_eq("head_no_rd", a_data_out, 10'h101);
        check_eq("level3", a_level, 3);
        for (int i = 0; i < 3; i++) drive(0, '0, 1, 0, 0);
        check_eq("drained_reg", b_data_out, 10'h103);
        idle();

        // overflow drops data, clr_err clears
        for (int i = 0; i < DEPTH; i++) drive(1, 10'h200 + DW'(i), 0, 0, 0);
        drive(1, 10'h3FF, 0, 0, 0);
        check_eq("ov_set", a_ov, 1);
        drive(0, '0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) drive(0, '0, 1, 0, 0);
        idle();

        // simultaneous write/read while full
        for (int i = 0; i < DEPTH; i++) drive(1, 10'h010 + DW'(i), 0, 0, 0);
        drive(1, 10'h055, 1, 0, 0);
        check_eq("full_wr_rd_ov", a_ov, 0);
        for (int i = 0; i < DEPTH; i++) drive(0, '0, 1, 0, 0);
        check_eq("last_055", b_data_out, 10'h055);

        // underflow, and empty wr+rd takes only the write
        drive(0, '0, 1, 0, 0);
        drive(1, 10'h011, 1, 0, 0);
        idle();
        check_eq("ud_sticky", a_ud, 1);
        drive(0, '0, 0, 0, 1);
        drive(0, '0, 1, 0, 0);

        // threshold behaviour
        thr_level = 3'd2;
        drive(1, 10'h001, 0, 0, 0);
        drive(1, 10'h002, 0, 0, 0);
        check_eq("thr2_rise", a_thr, 1);
        drive(0, '0, 1, 0, 0);
        thr_level = 3'd0;
        idle();
        check_eq("thr0_lvl1", a_thr, 1);
        thr_level = 3'd7;
        idle();
        for (int i = 0; i < 3; i++) drive(1, 10'h020 + DW'(i), 0, 0, 0);
        check_eq("thr7_full", a_thr, 1);
        for (int i = 0; i < DEPTH; i++) drive(0, '0, 1, 0, 0);
        thr_level = 3'd0;

        // registered read latency, flush, reset mid-stream
        drive(1, 10'h0AA, 0, 0, 0);
        drive(0, '0, 1, 0, 0);
        check_eq("reg_latency", b_data_out, 10'h0AA);
        for (int i = 0; i < 3; i++) drive(1, 10'h030 + DW'(i), 0, 0, 0);
        drive(1, 10'h0FF, 1, 1, 0);
        check_eq("flush_empty", a_empty, 1);
        drive(1, 10'h044, 0, 0, 0);
        rst_n = 1'b0;
        drive(1, 10'h045, 0, 0, 0);
        check_eq("rst_level", a_level, 0);
        rst_n = 1'b1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n % 50 == 0) thr_level = PW'(0) + (PW+1)'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 199) != 0);
            drive($urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 50,
                  $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
        end
        rst_n = 1'b1;
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
